// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Function : Instruction fetch stage. PC, valid/ready instruction-memory
//            read, stall hold and branch redirect with stale-response drain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HAVE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              r_state, w_state;
  logic [ADDR_W-1:0]   r_pc, w_pc;
  logic                r_req, w_req;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [15:0]         r_instr, w_instr;
  logic                r_valid, w_valid;
  logic [ADDR_W-1:0]   r_pc_out, w_pc_out;
  logic                w_take;

  assign w_take = r_valid & ~stall;

  always_comb begin
    w_state  = r_state;
    w_pc     = r_pc;
    w_req    = r_req;
    w_addr   = r_addr;
    w_instr  = r_instr;
    w_valid  = r_valid;
    w_pc_out = r_pc_out;

    case (r_state)
      S_IDLE: begin
        w_state = S_REQ;
        w_req   = 1'b1;
        w_addr  = redirect_valid ? redirect_pc : r_pc;
        if (redirect_valid) w_pc = redirect_pc;
      end
      S_REQ: begin
        if (redirect_valid) begin
          w_pc = redirect_pc;
          // An accepted request may be replaced; an outstanding one must be drained.
          if (imem_ready) w_addr = redirect_pc;
          else            w_state = S_DRAIN;
        end else if (imem_ready) begin
          w_instr  = imem_rdata;
          w_pc_out = r_addr;
          w_valid  = 1'b1;
          w_pc     = r_pc + 1'b1;
          w_req    = 1'b0;
          w_state  = S_HAVE;
        end
      end
      S_HAVE: begin
        if (redirect_valid) begin
          w_pc    = redirect_pc;
          w_valid = 1'b0;
          w_req   = 1'b1;
          w_addr  = redirect_pc;
          w_state = S_REQ;
        end else if (w_take) begin
          w_valid = 1'b0;
          w_req   = 1'b1;
          w_addr  = r_pc;
          w_state = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) w_pc = redirect_pc;
        // Stale response is dropped; reissue at the latest target.
        if (imem_ready) begin
          w_addr  = redirect_valid ? redirect_pc : r_pc;
          w_state = S_REQ;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_req    <= 1'b0;
      r_addr   <= RESET_PC;
      r_instr  <= 16'h0000;
      r_valid  <= 1'b0;
      r_pc_out <= RESET_PC;
    end else begin
      r_state  <= w_state;
      r_pc     <= w_pc;
      r_req    <= w_req;
      r_addr   <= w_addr;
      r_instr  <= w_instr;
      r_valid  <= w_valid;
      r_pc_out <= w_pc_out;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign pc_out      = r_pc_out;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Function : Randomized bench for fetch_unit against a transaction-level model
//            of the instruction stream and memory handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam int          ADDR_W   = 8;
  localparam logic [7:0]  RESET_PC = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic [15:0] instr;
  logic        instr_valid;
  logic [7:0]  pc_out;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h0;

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc_out        (pc_out),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return 16'h1000 + {8'h00, a};
  endfunction

  // Model state: next address the stream should deliver, and whether an
  // outstanding memory response belongs to a superseded fetch.
  logic [7:0]  exp_pc;
  bit          stale;
  bit          pending;
  int          remaining;
  int          since;
  int          delivered;
  logic [7:0]  last_pc;
  bit          have_last;
  bit          saw_wrap, saw40, saw5;

  bit          p_valid, p_stall, p_redirect, p_req, p_ready, p_stale;
  logic [15:0] p_instr;
  logic [7:0]  p_pc_out, p_addr;

  int          stall_pct = 0, redir_pct = 0, wait_min = 0, wait_max = 0;
  int          stall_hold = 0;
  bit          force_redir = 1'b0;
  logic [7:0]  force_pc = 8'h0;
  bit          arm_at5 = 1'b0;

  task automatic model_reset();
    exp_pc = RESET_PC; stale = 0; pending = 0; remaining = 0; since = 0;
    have_last = 0;
    p_valid = 0; p_stall = 0; p_redirect = 0; p_req = 0; p_ready = 0; p_stale = 0;
    p_instr = 16'h0; p_pc_out = RESET_PC; p_addr = RESET_PC;
  endtask

  task automatic step();
    bit new_exp;
    // Check results of the edge just taken.
    if (p_req && !p_ready) begin
      check("req_hold", imem_req, 1);
      check("addr_hold", imem_addr, p_addr);
    end
    new_exp = p_req && p_ready && !p_stale;
    if (p_redirect) begin
      check("redir_no_valid", instr_valid, 0);
      since++;
    end else if (p_valid && p_stall) begin
      check("stall_valid", instr_valid, 1);
      check("stall_instr", instr, p_instr);
      check("stall_pc", pc_out, p_pc_out);
      check("stall_req", imem_req, 0);
      since++;
    end else begin
      check("valid", instr_valid, new_exp);
      if (p_valid) check("req_after_take", imem_req, 1);
      if (instr_valid) begin
        check("pc_out", pc_out, exp_pc);
        check("instr", instr, mem_word(exp_pc));
        if (have_last && last_pc == 8'hFF && pc_out == 8'h00) saw_wrap = 1;
        if (pc_out == 8'h40) saw40 = 1;
        if (pc_out == 8'h05) saw5 = 1;
        last_pc = pc_out; have_last = 1;
        exp_pc = exp_pc + 8'h01;
        delivered++;
        since = 0;
      end else begin
        since++;
      end
    end
    if (since == 60) check("progress", 0, 1);

    // Memory responder.
    if (imem_req) begin
      if (!pending) begin
        pending = 1;
        remaining = $urandom_range(wait_max, wait_min);
      end
      imem_ready = (remaining == 0);
      if (imem_ready) pending = 0;
      else remaining--;
    end else begin
      imem_ready = 1'b0;
    end
    imem_rdata = imem_ready ? mem_word(imem_addr) : 16'($urandom);

    // Downstream and redirect stimulus.
    stall = ($urandom_range(99) < stall_pct);
    if (stall_hold > 0 && instr_valid) begin
      stall = 1'b1;
      stall_hold--;
    end
    redirect_valid = ($urandom_range(99) < redir_pct);
    redirect_pc    = 8'($urandom);
    if (force_redir) begin
      redirect_valid = 1'b1; redirect_pc = force_pc; force_redir = 1'b0;
    end
    if (arm_at5 && imem_req && imem_addr == 8'h05 && !imem_ready) begin
      redirect_valid = 1'b1; redirect_pc = 8'h40; arm_at5 = 1'b0;
    end

    p_stale = stale;
    if (redirect_valid) begin
      exp_pc = redirect_pc;
      if (imem_req && !imem_ready) stale = 1;
      else if (imem_req && imem_ready) stale = 0;
    end else if (imem_req && imem_ready) begin
      stale = 0;
    end

    p_valid = instr_valid; p_stall = stall; p_redirect = redirect_valid;
    p_req = imem_req; p_ready = imem_ready; p_instr = instr;
    p_pc_out = pc_out; p_addr = imem_addr;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      step();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   imem_req, 0);
    check({tag, "_addr"},  imem_addr, RESET_PC);
    check({tag, "_instr"}, instr, 16'h0000);
    check({tag, "_valid"}, instr_valid, 0);
    check({tag, "_pc"},    pc_out, RESET_PC);
  endtask

  task automatic do_reset(input string tag);
    #1 rst_n = 1'b0;
    stall = 0; redirect_valid = 0; imem_ready = 0; stall_hold = 0;
    #1 check_reset_vals(tag);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    delivered = 0; saw_wrap = 0; saw40 = 0; saw5 = 0;
    repeat (2) @(posedge clk);
    #1 check_reset_vals("rst");
    @(negedge clk) rst_n = 1'b1;

    // Zero-wait, no stall: request at edge 1, one instruction per 2 cycles.
    @(posedge clk); #1;
    check("req_edge1", imem_req, 1);
    check("addr_edge1", imem_addr, RESET_PC);
    step();
    delivered = 0;
    run(19);
    check("throughput", delivered, 10);

    // Fixed 3-cycle memory wait with a 5-cycle stall.
    wait_min = 3; wait_max = 3;
    run(10);
    stall_hold = 5;
    run(20);
    check("stall_released", stall_hold, 0);

    // Redirect to 0x40 while address 5 is outstanding.
    do_reset("rst_mid");
    saw40 = 0; saw5 = 0; arm_at5 = 1;
    run(60);
    check("redir40_seen", saw40, 1);
    check("addr5_dropped", saw5, 0);

    // Wrap from 0xFF to 0x00.
    wait_min = 0; wait_max = 2;
    force_pc = 8'hFF; force_redir = 1; saw_wrap = 0;
    run(30);
    check("wrap_ff_00", saw_wrap, 1);

    // Randomized traffic.
    stall_pct = 30; redir_pct = 8; wait_min = 0; wait_max = 3;
    run(600);

    // Asynchronous reset while requesting and while holding an instruction.
    for (int k = 0; k < 50 && !(imem_req && !instr_valid); k++) run(1);
    check("reach_req", imem_req, 1);
    do_reset("rst_req");
    run(200);
    for (int k = 0; k < 50 && !instr_valid; k++) run(1);
    check("reach_have", instr_valid, 1);
    do_reset("rst_have");
    stall_pct = 0; redir_pct = 0; wait_min = 0; wait_max = 0;
    @(posedge clk); #1;
    check("restart_addr", imem_addr, RESET_PC);
    step();
    run(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
